pwm_ram_arbiter: RTL and testbench
==================================

Name: pwm_ram_arbiter

Overview:
- Shares the single-port TAPWM pattern RAM between two requesters: the SPI host command path (read/write, commands 0x00/0x01) and the PWM playback fetch engine (read-only).
- Sits between the SPI command decoder / TAPWM sequencer and the RAM.
- Playback has priority. A bounded-wait counter guarantees host progress.
- Fixed 4-cycle transaction with a registered req/ack handshake on both sides.

Parameters:
- ADDR_W, 8, RAM address width (matches the 8-bit SPI Addr byte).
- DATA_W, 32, RAM data width (matches {Data0,Data1,Data2,Data3}).
- HOST_MAX_WAIT, 16, cycles Host_Req may be refused before host is forced ahead of playback; legal range 1..255.

Ports:
- Clk  in  1  system clock (BUFG output).
- Reset  in  1  synchronous, active-high reset.
- Host_Req  in  1  host access request, level, held until Host_Ack.
- Host_Write  in  1  1=write, 0=read; sampled with Host_Req at grant.
- Host_Addr  in  ADDR_W  host address.
- Host_WData  in  DATA_W  host write data.
- Host_Ack  out  1  one-cycle completion pulse.
- Host_RData  out  DATA_W  read data, valid while Host_Ack=1, held afterwards.
- Play_Req  in  1  playback fetch request, level, held until Play_Ack.
- Play_Addr  in  ADDR_W  playback address.
- Play_Ack  out  1  one-cycle completion pulse.
- Play_RData  out  DATA_W  fetched word, valid while Play_Ack=1, held afterwards.
- Ram_En  out  1  RAM enable.
- Ram_We  out  1  RAM write enable.
- Ram_Addr  out  ADDR_W  RAM address.
- Ram_WData  out  DATA_W  RAM write data.
- Ram_RData  in  DATA_W  RAM read data, valid 1 cycle after Ram_En with Ram_We=0.
- Host_Starved  out  1  sticky flag: host wait counter reached HOST_MAX_WAIT at least once; cleared only by Reset.

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs registered.
  - Reset, synchronous active-high: state=IDLE; Ram_En=Ram_We=0; Ram_Addr=0; Ram_WData=0; Host_Ack=Play_Ack=0; Host_RData=Play_RData=0; wait counter=0; Host_Starved=0; owner=PLAY.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one cycle each except IDLE.
- IDLE: arbitrate at each edge.
  - Host is forced (force_host) if wait counter == HOST_MAX_WAIT and Host_Req=1. Host wins.
  - Otherwise, if Play_Req=1, playback wins.
  - Otherwise, if Host_Req=1, host wins.
  - Otherwise stay in IDLE.
  - Winner's address, write flag and write data are latched; owner is recorded; next state is ISSUE.
- ISSUE:
  - Ram_En=1; Ram_We=1 only for a host write; Ram_Addr/Ram_WData from the latch.
  - Playback never drives Ram_We.
- WAIT: Ram_En=Ram_We=0; Ram_RData is valid this cycle and is captured into the owner's RData register at the edge ending WAIT.
  - For a host write, Host_RData is left unchanged.
- RESP: the owner's Ack=1 for exactly one cycle. The other Ack stays 0.
- Handshake rules:
  - Requesters keep Req and operands stable from assertion until they see Ack.
  - Requesters drop Req at the edge that samples Ack, so Req is low in the next IDLE cycle.
  - Req changes while not in IDLE are ignored.
  - Latency: Req seen at edge N gives Ack high in cycle N+3. Peak throughput is one access per 4 cycles.
- Wait counter (8 bit):
  - Increments each cycle Host_Req=1 and the current or pending transaction is not host-owned.
  - Saturates at HOST_MAX_WAIT.
  - Clears when the host is granted.
  - Holds while Host_Req=0.
- Host_Starved sets on the cycle the counter reaches HOST_MAX_WAIT.
- Simultaneous Play_Req and Host_Req in IDLE with counter < HOST_MAX_WAIT: playback wins, and the counter keeps counting.
- Reset mid-transaction: the transaction is abandoned; no Ack is issued; a write issued in ISSUE may have completed in RAM. Requesters re-request after reset.
- No address wrap logic: ADDR_W addresses map directly to the RAM.

Decomposition:
- Shared package (pwm_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3;
  - owner constants OWN_PLAY=1'b0, OWN_HOST=1'b1;
  - ADDR_W/DATA_W defaults shared with TAPWM.
- No sub-module required. The wait counter plus starvation flag may be split into pwm_arb_wait_ctr if the verification engineer wants it unit-tested separately.

Test Plan:
- Host write, Host_Addr=0x05, Host_WData=0xDEADBEEF, playback idle -> Ram_En=Ram_We=1 with Addr 0x05 one cycle after grant; Host_Ack at N+3; a subsequent host read of 0x05 returns Host_RData=0xDEADBEEF.
- Play_Req and Host_Req (read 0x10) asserted the same cycle, counter 0 -> playback granted first, Play_Ack at N+3; host granted in the next IDLE, Host_Ack at N+7.
- Play_Req held continuously (re-requested every IDLE), Host_Req held, HOST_MAX_WAIT=4 -> host granted on the first IDLE after the counter reaches 4; Host_Starved=1 and stays 1; counter back to 0.
- Playback fetch of address 0xFF after a host write of 0x00000001 there -> Play_RData=0x00000001; Ram_We never high during the playback transaction.
- Reset asserted in the WAIT state of a host read -> next cycle all outputs are at reset values; no Host_Ack; a new Host_Req completes normally.
- Host read of 0x20 (holds 0xA5A5A5A5), then a host write -> Host_RData stays 0xA5A5A5A5 after the write's Ack.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared encodings for the TAPWM pattern RAM arbiter.
// State and owner codes plus the default RAM geometry.
package pwm_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OWN_PLAY = 1'b0;
  localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/pwm_arb_wait_ctr.sv
// Bounded-wait counter that forces the host ahead of playback,
// plus the sticky starvation flag.
module pwm_arb_wait_ctr #(
  parameter int HOST_MAX_WAIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic grant_i,
  input  logic busy_i,
  output logic force_o,
  output logic starved_o
);

  localparam logic [7:0] MaxWait = 8'(HOST_MAX_WAIT);

  logic [7:0] cnt_q, cnt_d;
  logic       starved_q, starved_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      cnt_d = '0;
    end else if (req_i && !busy_i && cnt_q < MaxWait) begin
      cnt_d = cnt_q + 8'd1;
    end
    starved_d = starved_q | (cnt_d == MaxWait);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      starved_q <= starved_d;
    end
  end

  assign force_o   = req_i && (cnt_q == MaxWait);
  assign starved_o = starved_q;

endmodule

// File: rtl/pwm_ram_arbiter.sv
// Single-port pattern RAM shared by SPI host and PWM playback.
// Playback first; the wait counter bounds host latency.
module pwm_ram_arbiter
  import pwm_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int HOST_MAX_WAIT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Host_Req,
  input  logic              Host_Write,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [DATA_W-1:0] Host_WData,
  output logic              Host_Ack,
  output logic [DATA_W-1:0] Host_RData,
  input  logic              Play_Req,
  input  logic [ADDR_W-1:0] Play_Addr,
  output logic              Play_Ack,
  output logic [DATA_W-1:0] Play_RData,
  output logic              Ram_En,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_WData,
  input  logic [DATA_W-1:0] Ram_RData,
  output logic              Host_Starved
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   wr_q, wr_d;
  logic   en_q, en_d;
  logic   we_q, we_d;
  logic   hack_q, hack_d;
  logic   pack_q, pack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hrd_q, hrd_d;
  logic [DATA_W-1:0] prd_q, prd_d;

  logic host_gnt;
  logic host_busy;
  logic force_host;

  assign host_busy = (state_q != ST_IDLE) && (owner_q == OWN_HOST);

  pwm_arb_wait_ctr #(
    .HOST_MAX_WAIT(HOST_MAX_WAIT)
  ) u_wait (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .req_i    (Host_Req),
    .grant_i  (host_gnt),
    .busy_i   (host_busy),
    .force_o  (force_host),
    .starved_o(Host_Starved)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    hack_d   = 1'b0;
    pack_d   = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hrd_d    = hrd_q;
    prd_d    = prd_q;
    host_gnt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (force_host || (Host_Req && !Play_Req)) begin
          host_gnt = 1'b1;
          state_d  = ST_ISSUE;
          owner_d  = OWN_HOST;
          wr_d     = Host_Write;
          en_d     = 1'b1;
          we_d     = Host_Write;
          addr_d   = Host_Addr;
          wdata_d  = Host_WData;
        end else if (Play_Req) begin
          state_d  = ST_ISSUE;
          owner_d  = OWN_PLAY;
          wr_d     = 1'b0;
          en_d     = 1'b1;
          addr_d   = Play_Addr;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        // RAM output is valid now; a host write keeps old read data
        if (owner_q == OWN_PLAY) begin
          prd_d  = Ram_RData;
          pack_d = 1'b1;
        end else begin
          if (!wr_q) hrd_d = Ram_RData;
          hack_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_PLAY;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      hack_q  <= 1'b0;
      pack_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hrd_q   <= '0;
      prd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      we_q    <= we_d;
      hack_q  <= hack_d;
      pack_q  <= pack_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hrd_q   <= hrd_d;
      prd_q   <= prd_d;
    end
  end

  assign Ram_En     = en_q;
  assign Ram_We     = we_q;
  assign Ram_Addr   = addr_q;
  assign Ram_WData  = wdata_q;
  assign Host_Ack   = hack_q;
  assign Play_Ack   = pack_q;
  assign Host_RData = hrd_q;
  assign Play_RData = prd_q;

endmodule

// File: tb/tb_pwm_ram_arbiter.sv
// Directed bench for pwm_ram_arbiter with a behavioural RAM.
// HOST_MAX_WAIT is 4 so starvation is reached quickly.
module tb_pwm_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Host_Req = 1'b0;
  logic          Host_Write = 1'b0;
  logic [AW-1:0] Host_Addr = '0;
  logic [DW-1:0] Host_WData = '0;
  logic          Host_Ack;
  logic [DW-1:0] Host_RData;
  logic          Play_Req = 1'b0;
  logic [AW-1:0] Play_Addr = '0;
  logic          Play_Ack;
  logic [DW-1:0] Play_RData;
  logic          Ram_En;
  logic          Ram_We;
  logic [AW-1:0] Ram_Addr;
  logic [DW-1:0] Ram_WData;
  logic [DW-1:0] Ram_RData;
  logic          Host_Starved;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [256];

  pwm_ram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .HOST_MAX_WAIT(4)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Host_Req    (Host_Req),
    .Host_Write  (Host_Write),
    .Host_Addr   (Host_Addr),
    .Host_WData  (Host_WData),
    .Host_Ack    (Host_Ack),
    .Host_RData  (Host_RData),
    .Play_Req    (Play_Req),
    .Play_Addr   (Play_Addr),
    .Play_Ack    (Play_Ack),
    .Play_RData  (Play_RData),
    .Ram_En      (Ram_En),
    .Ram_We      (Ram_We),
    .Ram_Addr    (Ram_Addr),
    .Ram_WData   (Ram_WData),
    .Ram_RData   (Ram_RData),
    .Host_Starved(Host_Starved)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Ram_En) begin
      if (Ram_We) mem[Ram_Addr] <= Ram_WData;
      else        Ram_RData <= mem[Ram_Addr];
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Full host transaction starting in IDLE; returns Ack and RData seen in RESP.
  task automatic host_txn(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          output logic ack, output logic [DW-1:0] rd);
    Host_Write = w;
    Host_Addr  = a;
    Host_WData = d;
    Host_Req   = 1'b1;
    tick;
    tick;
    tick;
    ack = Host_Ack;
    rd  = Host_RData;
    Host_Req = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick;
    tick;
    n_tests++;
    if ({Ram_En, Ram_We, Host_Ack, Play_Ack, Host_Starved} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000",
               {Ram_En, Ram_We, Host_Ack, Play_Ack, Host_Starved});
    end
    n_tests++;
    if ({Ram_Addr, Ram_WData, Host_RData, Play_RData} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h %h want zeros",
               Ram_Addr, Ram_WData, Host_RData, Play_RData);
    end
    Reset = 1'b0;
    tick;
    tick;
    n_tests++;
    if (Ram_En !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req Ram_En got %b want 0", Ram_En);
    end
  endtask

  task automatic test_host_write_read;
    logic          ack;
    logic [DW-1:0] rd;
    Host_Write = 1'b1;
    Host_Addr  = 8'h05;
    Host_WData = 32'hDEADBEEF;
    Host_Req   = 1'b1;
    tick;
    n_tests++;
    if ({Ram_En, Ram_We, Ram_Addr, Ram_WData} !== {2'b11, 8'h05, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL wr_issue got en=%b we=%b a=%h d=%h want 1 1 05 deadbeef",
               Ram_En, Ram_We, Ram_Addr, Ram_WData);
    end
    tick;
    n_tests++;
    if ({Ram_En, Ram_We, Host_Ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_wait got en/we/ack=%b want 000", {Ram_En, Ram_We, Host_Ack});
    end
    tick;
    n_tests++;
    if ({Host_Ack, Play_Ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_ack got %b want 10", {Host_Ack, Play_Ack});
    end
    Host_Req = 1'b0;
    tick;
    n_tests++;
    if (Host_Ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack_pulse got %b want 0", Host_Ack);
    end
    host_txn(1'b0, 8'h05, 32'h0, ack, rd);
    n_tests++;
    if ({ack, rd} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_back got ack=%b rd=%h want 1 deadbeef", ack, rd);
    end
  endtask

  task automatic test_simultaneous;
    logic          ack;
    logic [DW-1:0] rd;
    host_txn(1'b1, 8'h10, 32'h11111111, ack, rd);
    host_txn(1'b1, 8'h30, 32'h33333333, ack, rd);
    Play_Addr  = 8'h30;
    Play_Req   = 1'b1;
    Host_Write = 1'b0;
    Host_Addr  = 8'h10;
    Host_Req   = 1'b1;
    tick;
    n_tests++;
    if ({Ram_Addr, Ram_We} !== {8'h30, 1'b0}) begin
      n_fail++;
      $display("FAIL sim_play_first got a=%h we=%b want 30 0", Ram_Addr, Ram_We);
    end
    tick;
    tick;
    n_tests++;
    if ({Play_Ack, Host_Ack, Play_RData} !== {2'b10, 32'h33333333}) begin
      n_fail++;
      $display("FAIL sim_play_ack got pa=%b ha=%b rd=%h want 1 0 33333333",
               Play_Ack, Host_Ack, Play_RData);
    end
    Play_Req = 1'b0;
    tick;
    tick;
    n_tests++;
    if (Ram_Addr !== 8'h10) begin
      n_fail++;
      $display("FAIL sim_host_next got a=%h want 10", Ram_Addr);
    end
    tick;
    tick;
    n_tests++;
    if ({Host_Ack, Play_Ack, Host_RData, Play_RData} !==
        {2'b10, 32'h11111111, 32'h33333333}) begin
      n_fail++;
      $display("FAIL sim_host_ack got ha=%b pa=%b hrd=%h prd=%h want 1 0 11111111 33333333",
               Host_Ack, Play_Ack, Host_RData, Play_RData);
    end
    Host_Req = 1'b0;
    tick;
  endtask

  task automatic test_starvation;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    n_tests++;
    if (Host_Starved !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_init got %b want 0", Host_Starved);
    end
    Play_Addr  = 8'h30;
    Play_Req   = 1'b1;
    Host_Write = 1'b0;
    Host_Addr  = 8'h10;
    Host_Req   = 1'b1;
    tick;
    tick;
    tick;
    n_tests++;
    if ({Play_Ack, Host_Starved} !== 2'b10) begin
      n_fail++;
      $display("FAIL starve_cnt3 got ack/starved=%b want 10", {Play_Ack, Host_Starved});
    end
    tick;
    n_tests++;
    if (Host_Starved !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_set got %b want 1", Host_Starved);
    end
    tick;
    n_tests++;
    if (Ram_Addr !== 8'h10) begin
      n_fail++;
      $display("FAIL starve_force got a=%h want 10", Ram_Addr);
    end
    tick;
    tick;
    n_tests++;
    if ({Host_Ack, Host_RData} !== {1'b1, 32'h11111111}) begin
      n_fail++;
      $display("FAIL starve_host_ack got ack=%b rd=%h want 1 11111111",
               Host_Ack, Host_RData);
    end
    Host_Req = 1'b0;
    tick;
    Host_Req = 1'b1;
    tick;
    n_tests++;
    if (Ram_Addr !== 8'h30) begin
      n_fail++;
      $display("FAIL starve_cnt_clr got a=%h want 30", Ram_Addr);
    end
    tick;
    tick;
    Play_Req = 1'b0;
    tick;
    tick;
    n_tests++;
    if (Ram_Addr !== 8'h10) begin
      n_fail++;
      $display("FAIL starve_host2 got a=%h want 10", Ram_Addr);
    end
    tick;
    tick;
    Host_Req = 1'b0;
    tick;
    n_tests++;
    if (Host_Starved !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_sticky got %b want 1", Host_Starved);
    end
  endtask

  task automatic test_play_fetch;
    logic          ack;
    logic [DW-1:0] rd;
    logic          we_seen;
    host_txn(1'b1, 8'hFF, 32'h00000001, ack, rd);
    Play_Addr = 8'hFF;
    Play_Req  = 1'b1;
    we_seen   = 1'b0;
    tick;
    n_tests++;
    if ({Ram_En, Ram_Addr} !== {1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL play_issue got en=%b a=%h want 1 ff", Ram_En, Ram_Addr);
    end
    we_seen |= Ram_We;
    tick;
    we_seen |= Ram_We;
    tick;
    we_seen |= Ram_We;
    n_tests++;
    if ({Play_Ack, Play_RData} !== {1'b1, 32'h00000001}) begin
      n_fail++;
      $display("FAIL play_data got ack=%b rd=%h want 1 00000001", Play_Ack, Play_RData);
    end
    Play_Req = 1'b0;
    tick;
    we_seen |= Ram_We;
    n_tests++;
    if (we_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL play_no_we got %b want 0", we_seen);
    end
    n_tests++;
    if ({Play_Ack, Play_RData} !== {1'b0, 32'h00000001}) begin
      n_fail++;
      $display("FAIL play_hold got ack=%b rd=%h want 0 00000001", Play_Ack, Play_RData);
    end
  endtask

  task automatic test_reset_mid;
    logic          ack;
    logic [DW-1:0] rd;
    logic          ack_seen;
    host_txn(1'b1, 8'h20, 32'hA5A5A5A5, ack, rd);
    Host_Write = 1'b0;
    Host_Addr  = 8'h20;
    Host_Req   = 1'b1;
    tick;
    tick;
    Reset    = 1'b1;
    Host_Req = 1'b0;
    tick;
    n_tests++;
    if ({Ram_En, Ram_We, Host_Ack, Play_Ack, Host_Starved} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl got %b want 00000",
               {Ram_En, Ram_We, Host_Ack, Play_Ack, Host_Starved});
    end
    n_tests++;
    if ({Ram_Addr, Ram_WData, Host_RData, Play_RData} !== '0) begin
      n_fail++;
      $display("FAIL midrst_data got %h %h %h %h want zeros",
               Ram_Addr, Ram_WData, Host_RData, Play_RData);
    end
    Reset    = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      ack_seen |= Host_Ack;
    end
    n_tests++;
    if (ack_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_ack got %b want 0", ack_seen);
    end
    host_txn(1'b0, 8'h20, 32'h0, ack, rd);
    n_tests++;
    if ({ack, rd} !== {1'b1, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL midrst_retry got ack=%b rd=%h want 1 a5a5a5a5", ack, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic          ack;
    logic [DW-1:0] rd;
    host_txn(1'b0, 8'h20, 32'h0, ack, rd);
    host_txn(1'b1, 8'h21, 32'h12345678, ack, rd);
    n_tests++;
    if ({ack, rd} !== {1'b1, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL wr_keeps_rdata got ack=%b rd=%h want 1 a5a5a5a5", ack, rd);
    end
    n_tests++;
    if (Host_RData !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL rdata_held got %h want a5a5a5a5", Host_RData);
    end
    host_txn(1'b0, 8'h21, 32'h0, ack, rd);
    n_tests++;
    if ({ack, rd} !== {1'b1, 32'h12345678}) begin
      n_fail++;
      $display("FAIL b2b_read got ack=%b rd=%h want 1 12345678", ack, rd);
    end
  endtask

  initial begin
    test_reset;
    test_host_write_read;
    test_simultaneous;
    test_starvation;
    test_play_fetch;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
